// File: rtl/pipe_ctrl.sv
// Hazard/flow controller for the 5-stage core: jump flush, load-use bubble, EX busy stall, debug halt.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int BUSY_TIMEOUT = 64
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ld_in_ex_i,
  input  logic [4:0]  ld_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs2_i,
  input  logic        ex_busy_i,
  input  logic        halt_req_i,
  output logic        halt_ack_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        stall_id_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        busy_err_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_ld_stall_o,
  output logic [CNT_W-1:0] perf_busy_o,
  output logic [CNT_W-1:0] perf_flush_o
`endif
);

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {S_RUN, S_LD_STALL, S_BUSY, S_FLUSH, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [BW-1:0]   busy_cnt_q, busy_cnt_d, busy_base;
  logic            busy_ign_q, busy_err_q, ack_q;
  logic            ld_haz, busy_evt, busy_last, timeout, take_jump;
  logic            pc_hold, if_id_hold, id_ex_hold, stall_id, halt_ack;

  assign ld_haz = ld_in_ex_i && (ld_rd_i != '0) &&
                  ((ld_rd_i == id_rs1_i) || (id_use_rs2_i && (ld_rd_i == id_rs2_i)));
  // After a timeout, ex_busy_i is ignored until it drops so the pipe can drain.
  assign busy_evt  = ex_busy_i && !busy_ign_q;
  assign busy_base = (state_q == S_BUSY) ? busy_cnt_q : '0;
  assign busy_last = (busy_base == BW'(BUSY_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    busy_cnt_d  = '0;
    timeout     = 1'b0;
    take_jump   = 1'b0;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    id_ex_hold  = 1'b0;
    stall_id    = 1'b0;
    halt_ack    = 1'b0;
    case (state_q)
      S_HALT: begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        halt_ack   = ack_q && halt_req_i;
        if (!halt_req_i) state_d = S_RUN;
      end
      default: begin
        if (jump_en_i) begin
          take_jump  = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = S_FLUSH;
            flush_cnt_d = FW'(FLUSH_CYCLES - 1);
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_FLUSH) begin
          if_id_hold  = 1'b1;
          id_ex_hold  = 1'b1;
          flush_cnt_d = flush_cnt_q - FW'(1);
          if (flush_cnt_q == FW'(1)) state_d = S_RUN;
        end else if (busy_evt) begin
          pc_hold  = 1'b1;
          stall_id = 1'b1;
          if (busy_last) begin
            timeout = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d    = S_BUSY;
            busy_cnt_d = busy_base + BW'(1);
          end
        end else if (state_q == S_BUSY || state_q == S_LD_STALL) begin
          // Recovery cycle: a hazard still visible here is the one already bubbled.
          state_d = S_RUN;
        end else if (ld_haz) begin
          pc_hold    = 1'b1;
          stall_id   = 1'b1;
          id_ex_hold = 1'b1;
          state_d    = S_LD_STALL;
        end else if (halt_req_i) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
      busy_cnt_q  <= '0;
      busy_ign_q  <= 1'b0;
      busy_err_q  <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      if (timeout)         busy_ign_q <= 1'b1;
      else if (!ex_busy_i) busy_ign_q <= 1'b0;
      if (timeout) busy_err_q <= 1'b1;
      ack_q <= (state_q == S_HALT) && halt_req_i;
    end
  end

  assign pc_hold_o    = pc_hold    && !rst;
  assign if_id_hold_o = if_id_hold && !rst;
  assign id_ex_hold_o = id_ex_hold && !rst;
  assign stall_id_o   = stall_id   && !rst;
  assign halt_ack_o   = halt_ack   && !rst;
  assign jump_o       = take_jump  && !rst;
  assign jump_addr_o  = (take_jump && !rst) ? jump_addr_i : '0;
  assign busy_err_o   = busy_err_q && !rst;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_ld_q, perf_busy_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_q    <= '0;
      perf_busy_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      if (state_q == S_LD_STALL && !(&perf_ld_q)) perf_ld_q <= perf_ld_q + CNT_W'(1);
      if (state_q == S_BUSY && !(&perf_busy_q)) perf_busy_q <= perf_busy_q + CNT_W'(1);
      if ((state_q == S_FLUSH || take_jump) && !(&perf_flush_q))
        perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign perf_ld_stall_o = perf_ld_q;
  assign perf_busy_o     = perf_busy_q;
  assign perf_flush_o    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipe_ctrl;
  localparam int FC = 2;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en, ld_in_ex, use_rs2, ex_busy, halt_req;
  logic [31:0] jump_addr;
  logic [4:0]  ld_rd, rs1, rs2;
  logic        halt_ack, pc_hold, if_id_hold, id_ex_hold, stall_id, jump, busy_err;
  logic [31:0] jump_addr_out;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] perf_ld, perf_busy, perf_flush;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .ld_in_ex_i(ld_in_ex), .ld_rd_i(ld_rd), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_use_rs2_i(use_rs2), .ex_busy_i(ex_busy), .halt_req_i(halt_req),
    .halt_ack_o(halt_ack), .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold),
    .id_ex_hold_o(id_ex_hold), .stall_id_o(stall_id), .jump_o(jump),
    .jump_addr_o(jump_addr_out), .busy_err_o(busy_err)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_ld_stall_o(perf_ld), .perf_busy_o(perf_busy), .perf_flush_o(perf_flush)
`endif
  );

  // {ack, pc_hold, if_id_hold, id_ex_hold, stall_id, jump, busy_err, addr}
  function automatic logic [38:0] mk(input bit a, p, i, d, s, j, e, input logic [31:0] ad);
    return {a, p, i, d, s, j, e, ad};
  endfunction

  function automatic logic [38:0] outs();
    return {halt_ack, pc_hold, if_id_hold, id_ex_hold, stall_id, jump, busy_err, jump_addr_out};
  endfunction

  task automatic clr_in();
    jump_en = 0; jump_addr = '0; ld_in_ex = 0; ld_rd = '0; rs1 = '0; rs2 = '0;
    use_rs2 = 0; ex_busy = 0; halt_req = 0;
  endtask

  task automatic set_haz(input logic [4:0] rd);
    ld_in_ex = 1; ld_rd = rd; rs1 = rd;
  endtask

  task automatic test_reset();
    logic [38:0] got;
    clr_in(); rst = 1;
    @(negedge clk); @(negedge clk); #1;
    got = outs(); n_chk++;
    if (got !== '0) $display("FAIL reset_in got %h want 0", got); else n_pass++;
    @(negedge clk); rst = 0;
    @(negedge clk); #1;
    got = outs(); n_chk++;
    if (got !== '0) $display("FAIL reset_after got %h want 0", got); else n_pass++;
  endtask

  task automatic test_load_use();
    logic [38:0] got, want;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); clr_in();
      want = '0;
      case (c)
        0: begin set_haz(5'd5); want = mk(0,1,0,1,1,0,0,0); end
        1: set_haz(5'd5);
        2: begin ld_in_ex = 1; ld_rd = 5'd0; rs1 = 5'd0; end
        3: begin ld_in_ex = 1; ld_rd = 5'd7; rs1 = 5'd1; rs2 = 5'd7; use_rs2 = 1;
                 want = mk(0,1,0,1,1,0,0,0); end
        5: begin ld_in_ex = 1; ld_rd = 5'd7; rs1 = 5'd1; rs2 = 5'd7; use_rs2 = 0; end
        default: ;
      endcase
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL load_use c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_jump();
    logic [38:0] got, want;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); clr_in();
      want = '0;
      if (c == 0) begin jump_en = 1; jump_addr = 32'h0000_0100; want = mk(0,0,1,1,0,1,0,32'h100); end
      if (c == 1) want = mk(0,0,1,1,0,0,0,0);
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL jump c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_busy();
    logic [38:0] got, want;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); clr_in();
      ex_busy = (c < 10);
      want = (c < 10) ? mk(0,1,0,0,1,0,0,0) : '0;
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL busy c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_busy_timeout();
    logic [38:0] got, want;
    for (int c = 0; c < 74; c++) begin
      @(negedge clk); clr_in();
      ex_busy = (c < 70) || (c == 71);
      if (c < TO)                 want = mk(0,1,0,0,1,0,0,0);
      else if (c < 70)            want = mk(0,0,0,0,0,0,1,0);
      else if (c == 71)           want = mk(0,1,0,0,1,0,1,0);
      else                        want = mk(0,0,0,0,0,0,1,0);
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL busy_timeout c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_jump_over_load();
    logic [38:0] got, want;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); clr_in();
      want = '0;
      if (c < 2) set_haz(5'd9);
      if (c == 0) begin jump_en = 1; jump_addr = 32'h200; want = mk(0,0,1,1,0,1,0,32'h200); end
      if (c == 1) want = mk(0,0,1,1,0,0,0,0);
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL jump_over_load c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_halt_during_flush();
    logic [38:0] got, want;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); clr_in();
      halt_req = (c < 6);
      case (c)
        0: begin jump_en = 1; jump_addr = 32'h300; want = mk(0,0,1,1,0,1,0,32'h300); end
        1: want = mk(0,0,1,1,0,0,0,0);
        3, 6: want = mk(0,1,1,0,0,0,0,0);
        4, 5: want = mk(1,1,1,0,0,0,0,0);
        default: want = '0;
      endcase
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL halt_flush c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [38:0] got, want;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); clr_in();
      rst = (c == 3);
      ex_busy = (c < 3);
      want = (c < 3) ? mk(0,1,0,0,1,0,1,0) : '0;
      if (c == 4) begin set_haz(5'd3); want = mk(0,1,0,1,1,0,0,0); end
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL reset_mid_busy c%0d got %h want %h", c, got, want);
      else n_pass++;
`ifdef PIPE_CTRL_PERF_EN
      if (c == 4) begin
        n_chk++;
        if ({perf_ld, perf_busy, perf_flush} !== '0)
          $display("FAIL perf_reset got %h want 0", {perf_ld, perf_busy, perf_flush});
        else n_pass++;
      end
`endif
    end
    rst = 0;
  endtask

  task automatic test_random();
    int  flush_left, busy_len, halt_age;
    bit  ld_skip, ignore, err, halted, hz, bev, tmo;
    bit  e_ack, e_pc, e_ifid, e_idex, e_st, e_j, e_err;
    logic [31:0] e_addr;
    logic [38:0] got, want;
    @(negedge clk); clr_in(); rst = 1;
    @(negedge clk); rst = 0;
    flush_left = 0; busy_len = 0; halt_age = 0;
    ld_skip = 0; ignore = 0; err = 0; halted = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      jump_en   = ($urandom_range(0, 11) == 0);
      jump_addr = $urandom;
      ld_in_ex  = $urandom_range(0, 1);
      ld_rd     = 5'($urandom_range(0, 3));
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
      use_rs2   = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) ex_busy  = ~ex_busy;
      if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
      // reference: events resolved in priority order from the current situation
      {e_ack, e_pc, e_ifid, e_idex, e_st, e_j} = '0;
      e_addr = '0; e_err = err; tmo = 0;
      hz  = ld_in_ex && ld_rd != 0 && (ld_rd == rs1 || (use_rs2 && ld_rd == rs2));
      bev = ex_busy && !ignore;
      if (halted) begin
        e_pc = 1; e_ifid = 1; e_ack = (halt_age >= 1) && halt_req;
        if (halt_req) halt_age++; else halted = 0;
      end else if (jump_en) begin
        e_j = 1; e_addr = jump_addr; e_ifid = 1; e_idex = 1;
        flush_left = FC - 1; busy_len = 0; ld_skip = 0;
      end else if (flush_left > 0) begin
        e_ifid = 1; e_idex = 1; flush_left--;
      end else if (bev) begin
        e_pc = 1; e_st = 1; busy_len++; ld_skip = 0;
        if (busy_len == TO) begin tmo = 1; busy_len = 0; end
      end else if (busy_len > 0 || ld_skip) begin
        busy_len = 0; ld_skip = 0;
      end else if (hz) begin
        e_pc = 1; e_st = 1; e_idex = 1; ld_skip = 1;
      end else if (halt_req) begin
        halted = 1; halt_age = 0;
      end
      if (tmo) begin err = 1; ignore = 1; end
      else if (!ex_busy) ignore = 0;
      want = mk(e_ack, e_pc, e_ifid, e_idex, e_st, e_j, e_err, e_addr);
      #1; got = outs(); n_chk++;
      if (got !== want) $display("FAIL random c%0d got %h want %h", c, got, want);
      else n_pass++;
    end
    @(negedge clk); clr_in();
  endtask

  initial begin
    clr_in(); rst = 1;
    test_reset();
    test_load_use();
    test_jump();
    test_busy();
    test_jump_over_load();
    test_halt_during_flush();
    test_busy_timeout();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
